// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the combinational instruction ROM
// and loads the IF/ID register, honouring stalls, redirects and fetch traps.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] ROM_BYTES = 32'(ROM_WORDS * 4);

  typedef enum logic {
    ST_RUN,
    ST_FAULT
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_bad;

  assign rom_addr = pc;
  assign pc_plus4 = pc + 32'd4;
  // Range check in full width so a wrapped PC can never alias back into the ROM.
  assign pc_bad   = (pc[1:0] != 2'b00) || (pc >= ROM_BYTES);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      pc          <= RESET_PC;
      id_inst     <= '0;
      id_pc4      <= '0;
      id_valid    <= 1'b0;
      fault       <= 1'b0;
      fault_pc    <= '0;
      fetch_count <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (redirect) begin
            pc       <= redirect_pc;
            id_inst  <= '0;
            id_pc4   <= '0;
            id_valid <= 1'b0;
          end else if (stall) begin
            pc          <= pc;
            fetch_count <= fetch_count;
          end else if (pc_bad) begin
            state    <= ST_FAULT;
            fault    <= 1'b1;
            fault_pc <= pc;
            id_inst  <= '0;
            id_pc4   <= '0;
            id_valid <= 1'b0;
          end else begin
            pc          <= pc_plus4;
            id_inst     <= rom_inst;
            id_pc4      <= pc_plus4;
            id_valid    <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
          end
        end
        ST_FAULT: begin
          id_inst  <= '0;
          id_valid <= 1'b0;
        end
        default: state <= ST_FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: a 64-word ROM model feeds the DUT and a
// scoreboard queue holds the IF/ID contents expected after each driven edge.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] id_inst;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] rom [64];
  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  inst_fetch_unit #(.RESET_PC(32'h0000_0000), .ROM_WORDS(64)) dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_inst(rom_inst),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_inst(id_inst), .id_pc4(id_pc4), .id_valid(id_valid),
    .fault(fault), .fault_pc(fault_pc), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  assign rom_inst = rom[rom_addr[7:2]];

  function automatic logic [31:0] rom_word(int unsigned i);
    return (i == 0) ? 32'h0010_0443 : (32'hC0DE_0000 | 32'(i));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge with the given controls; the expected IF/ID contents are queued
  // before the edge and retired against the DUT 1 time unit after it.
  task automatic step(input string tag, input logic s, input logic r, input logic [31:0] rp,
                      input logic [31:0] e_inst, input logic [31:0] e_pc4, input logic e_valid);
    exp_t e;
    exp_t got;
    e.inst = e_inst; e.pc4 = e_pc4; e.valid = e_valid;
    sb.push_back(e);
    stall = s; redirect = r; redirect_pc = rp;
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check({tag, ".id_inst"},  id_inst,         got.inst);
    check({tag, ".id_pc4"},   id_pc4,          got.pc4);
    check({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, got.valid});
    stall = 1'b0; redirect = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = rom_word(i);

    do_reset();
    check("rst.rom_addr",    rom_addr,    32'h0);
    check("rst.id_inst",     id_inst,     32'h0);
    check("rst.id_pc4",      id_pc4,      32'h0);
    check("rst.id_valid",    {31'd0, id_valid}, 32'd0);
    check("rst.fault",       {31'd0, fault},    32'd0);
    check("rst.fault_pc",    fault_pc,    32'h0);
    check("rst.fetch_count", fetch_count, 32'h0);

    step("f0", 1'b0, 1'b0, 32'h0, 32'h0010_0443, 32'h4, 1'b1);
    check("f0.rom_addr", rom_addr, 32'h4);
    check("f0.count",    fetch_count, 32'd1);
    step("f1", 1'b0, 1'b0, 32'h0, rom_word(1), 32'h8, 1'b1);

    for (int k = 0; k < 3; k++) begin
      step("stall", 1'b1, 1'b0, 32'h0, rom_word(1), 32'h8, 1'b1);
      check("stall.rom_addr", rom_addr, 32'h8);
      check("stall.count",    fetch_count, 32'd2);
    end
    step("unstall", 1'b0, 1'b0, 32'h0, rom_word(2), 32'hC, 1'b1);
    check("unstall.count", fetch_count, 32'd3);
    step("f3", 1'b0, 1'b0, 32'h0, rom_word(3), 32'h10, 1'b1);

    step("redir_stall", 1'b1, 1'b1, 32'h14, 32'h0, 32'h0, 1'b0);
    check("redir_stall.rom_addr", rom_addr, 32'h14);
    check("redir_stall.count",    fetch_count, 32'd4);
    step("after_redir", 1'b0, 1'b0, 32'h0, rom_word(5), 32'h18, 1'b1);
    check("after_redir.count", fetch_count, 32'd5);

    step("redir_oob", 1'b0, 1'b1, 32'h100, 32'h0, 32'h0, 1'b0);
    check("redir_oob.rom_addr", rom_addr, 32'h100);
    check("redir_oob.fault",    {31'd0, fault}, 32'd0);
    step("trap_oob", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    check("trap_oob.fault",    {31'd0, fault}, 32'd1);
    check("trap_oob.fault_pc", fault_pc, 32'h100);
    step("fault_stall", 1'b1, 1'b0, 32'h0,  32'h0, 32'h0, 1'b0);
    step("fault_redir", 1'b0, 1'b1, 32'h20, 32'h0, 32'h0, 1'b0);
    check("fault_hold.rom_addr", rom_addr, 32'h100);
    check("fault_hold.fault",    {31'd0, fault}, 32'd1);
    check("fault_hold.fault_pc", fault_pc, 32'h100);
    check("fault_hold.count",    fetch_count, 32'd5);

    do_reset();
    check("rst2.fault",    {31'd0, fault}, 32'd0);
    check("rst2.rom_addr", rom_addr, 32'h0);
    check("rst2.count",    fetch_count, 32'd0);
    step("redir_mis", 1'b0, 1'b1, 32'h6, 32'h0, 32'h0, 1'b0);
    check("redir_mis.rom_addr", rom_addr, 32'h6);
    step("trap_mis", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    check("trap_mis.fault",    {31'd0, fault}, 32'd1);
    check("trap_mis.fault_pc", fault_pc, 32'h6);
    do_reset();
    check("rst3.fault",    {31'd0, fault}, 32'd0);
    check("rst3.rom_addr", rom_addr, 32'h0);

    for (int i = 0; i < 9; i++)
      step("seq", 1'b0, 1'b0, 32'h0, rom_word(i), 32'(4 * (i + 1)), 1'b1);
    check("seq.count",  fetch_count, 32'd9);
    check("seq.id_pc4", id_pc4, 32'h24);

    // Last valid word fetches normally; the PC past it must trap.
    step("redir_last", 1'b0, 1'b1, 32'hFC, 32'h0, 32'h0, 1'b0);
    step("last_word",  1'b0, 1'b0, 32'h0, rom_word(63), 32'h100, 1'b1);
    check("last_word.count", fetch_count, 32'd10);
    step("past_end",   1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    check("past_end.fault",    {31'd0, fault}, 32'd1);
    check("past_end.fault_pc", fault_pc, 32'h100);

    do_reset();
    step("redir_top", 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    step("trap_top",  1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    check("trap_top.fault_pc", fault_pc, 32'hFFFF_FFFC);
    check("trap_top.count",    fetch_count, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
